vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator with a pixel-request pipeline; replaces the fixed-mode VGA driver.
//  Runs in the pixel-clock domain from the clock wizard. Counts h/v position and issues (x,y) requests to a pixel source.
//  Delays sync/blank by the source's fixed latency so the returned colour lines up with HSYNC/VSYNC at the pins.
//  Default mode: 1600x1200@60 Hz, 162 MHz pixel clock.
// PARAMETERS
//  H_ACTIVE      1600  visible pixels per line
//  H_FP          64    horizontal front porch (clocks)
//  H_SYNC        192   horizontal sync width (clocks)
//  H_BP          304   horizontal back porch (clocks)
//  V_ACTIVE      1200  visible lines per frame
//  V_FP          1     vertical front porch (lines)
//  V_SYNC        3     vertical sync width (lines)
//  V_BP          46    vertical back porch (lines)
//  HS_POL        1     HSYNC active level (1 = active-high)
//  VS_POL        1     VSYNC active level
//  PIXEL_LATENCY 2     cycles from px_req to valid px_r/g/b; legal range 0..8
//  COLOR_W       4     bits per colour channel
// PORTS
//  clock_162   in   1         pixel clock
//  rst         in   1         synchronous active-high reset
//  px_req      out  1         high when (px_x,px_y) is in the active area
//  px_x        out  XW        requested column; XW = $clog2(H_TOTAL)
//  px_y        out  YW        requested row; YW = $clog2(V_TOTAL)
//  px_r        in   COLOR_W   red, PIXEL_LATENCY cycles after px_req
//  px_g        in   COLOR_W   green
//  px_b        in   COLOR_W   blue
//  HSYNC       out  1         horizontal sync to pins
//  VSYNC       out  1         vertical sync to pins
//  RED         out  COLOR_W   registered red
//  GREEN       out  COLOR_W   registered green
//  BLUE        out  COLOR_W   registered blue
//  frame_start out  1         1-cycle pulse when counters are at (0,0)
//  vblank      out  1         high while v_cnt >= V_ACTIVE, aligned with px_x/px_y
// BEHAVIOUR
//  - One clock (clock_162). Reset is synchronous and active-high (rst).
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap; at V_TOTAL-1 it wraps to 0.
//  - Stage 0 (combinational from counters): px_x = h_cnt, px_y = v_cnt.
//    - px_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//    - hs0 active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs0 uses the same rule with the V parameters.
//  - hs0, vs0 and de0 (= px_req) pass through a PIXEL_LATENCY-deep shift register; depth 0 means a direct wire.
//  - Output register (+1 cycle):
//    - HSYNC/VSYNC = delayed level XNOR'd with the matching *_POL, giving the active level when asserted.
//    - RGB = px_* if delayed de is 1, otherwise 0 (black during blanking, regardless of px_* content).
//  - Counter-to-pin latency is PIXEL_LATENCY+1 for sync and colour alike, so they stay mutually aligned.
//  - frame_start = (h_cnt==0 && v_cnt==0), undelayed. It is a request-side marker for the pixel source.
//  - Reset values, all applied on the clock edge while rst=1:
//    - h_cnt = v_cnt = 0;
//    - all delay stages = inactive/blank;
//    - HSYNC = !HS_POL, VSYNC = !VS_POL;
//    - RGB = 0, frame_start = 0.
//  - Reset mid-frame: the raster restarts; the first cycle after rst falls is (0,0) with frame_start=1. No partial sync pulse comes from stale delay stages.
//  - Boundaries:
//    - Last active pixel (H_ACTIVE-1) is followed by de=0.
//    - Line wrap and frame wrap happen in the same cycle at (H_TOTAL-1, V_TOTAL-1).
//    - VSYNC changes only on line boundaries.
//  - Elaboration-time $error if PIXEL_LATENCY > 8, or if any porch or sync parameter is 0.
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined: an internal colour-bar source replaces px_r/g/b.
//    - 8 vertical bars, each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black.
//    - Each channel is all-ones or 0; the source has latency PIXEL_LATENCY to match the pipeline.
//    - px_* inputs are ignored.
//  - Undefined: RGB comes from px_r/g/b as described above. No pattern logic is built.
// STRUCTURE
//  - Package vga_pkg holds:
//    - typedef struct {hs, vs, de} vga_ctl_t for the delay stages;
//    - typedef logic [COLOR_W-1:0] color_t;
//    - localparam mode presets: 1600x1200@60 and 1280x1024@60.
//  - One sub-module, vga_delay_line #(DEPTH, type T): a reset-to-inactive shift register, reused for the control bits and the test-pattern path.
// TESTING
//  1. Default params, run 2 frames -> HSYNC period 2160 clks, high 192; VSYNC period 2160*1250 clks, high 3 lines.
//  2. Source returns RGB=px_x[3:0] with latency 2 -> at first active output cycle RED=0; at the 5th active cycle RED=4; RGB=0 in all blank cycles.
//  3. Assert rst for 1 cycle at (h=900,v=600) -> next cycle px_x=0, px_y=0, frame_start=1; HSYNC/VSYNC stay inactive for >= PIXEL_LATENCY+1 cycles.
//  4. HS_POL=0, VS_POL=0 -> HSYNC idles high, pulses low for exactly 192 clks at h=1664..1855 (+latency).
//  5. PIXEL_LATENCY=0 and =8 -> edge of first de high at pins occurs exactly 1 and 9 cycles after px_req rises.
//  6. With VGA_TEST_PATTERN_EN -> active pixel 0 is white (all channels 0xF); pixel 1400 (bar 7) is black.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types, mode presets and the colour-bar lookup for the VGA timing generator.
package vga_pkg;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_ctl_t;

  localparam int COLOR_W_DEF = 4;
  typedef logic [COLOR_W_DEF-1:0] color_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } bar_rgb_t;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_1600X1200_60 = '{1600, 64, 192, 304, 1200, 1, 3, 46, 1'b1, 1'b1};
  localparam vga_mode_t MODE_1280X1024_60 = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic bar_rgb_t bar_color(input logic [2:0] idx);
    bar_rgb_t c;
    case (idx)
      3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1};
      3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0};
      3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
      3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
      3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1};
      3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
      3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
      default: c = '{r: 1'b0, g: 1'b0, b: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that clears to all-zero (inactive) on reset; depth 0 is a wire.
module vga_delay_line #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_reg
    T stage_q [DEPTH];
    T stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= T'(0);
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with a latency-matched pixel request pipeline.
// Define VGA_TEST_PATTERN_EN to replace px_r/g/b with an internal 8-bar colour pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE      = 1600,
  parameter int   H_FP          = 64,
  parameter int   H_SYNC        = 192,
  parameter int   H_BP          = 304,
  parameter int   V_ACTIVE      = 1200,
  parameter int   V_FP          = 1,
  parameter int   V_SYNC        = 3,
  parameter int   V_BP          = 46,
  parameter logic HS_POL        = 1'b1,
  parameter logic VS_POL        = 1'b1,
  parameter int   PIXEL_LATENCY = 2,
  parameter int   COLOR_W       = 4,
  localparam int  H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW            = $clog2(H_TOTAL),
  localparam int  YW            = $clog2(V_TOTAL)
) (
  input  logic               clock_162,
  input  logic               rst,
  output logic               px_req,
  output logic [XW-1:0]      px_x,
  output logic [YW-1:0]      px_y,
  input  logic [COLOR_W-1:0] px_r,
  input  logic [COLOR_W-1:0] px_g,
  input  logic [COLOR_W-1:0] px_b,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic [COLOR_W-1:0] RED,
  output logic [COLOR_W-1:0] GREEN,
  output logic [COLOR_W-1:0] BLUE,
  output logic               frame_start,
  output logic               vblank
);

  if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 8) begin : g_bad_latency
    $error("vga_timing_gen: PIXEL_LATENCY must be 0..8");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (int'(h_cnt_q) == H_TOTAL - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  vga_ctl_t ctl0, ctl_dly;

  always_comb begin
    px_x        = h_cnt_q;
    px_y        = v_cnt_q;
    px_req      = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    vblank      = int'(v_cnt_q) >= V_ACTIVE;
    // Gated by rst so the marker only fires once the raster is actually running.
    frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && !rst;
    ctl0.de     = px_req;
    ctl0.hs     = (int'(h_cnt_q) >= H_ACTIVE + H_FP) && (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
    ctl0.vs     = (int'(v_cnt_q) >= V_ACTIVE + V_FP) && (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);
  end

  vga_delay_line #(.DEPTH(PIXEL_LATENCY), .T(vga_ctl_t)) u_ctl_dly (
    .clk  (clock_162),
    .rst  (rst),
    .din  (ctl0),
    .dout (ctl_dly)
  );

  logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  bar_rgb_t pat0, pat_dly;
  int       bar_idx;
  logic     unused_px;

  always_comb begin
    bar_idx = int'(h_cnt_q) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    pat0 = bar_color(3'(bar_idx));
  end

  // Pattern is looked up at request time and aged by the same latency as an external source.
  vga_delay_line #(.DEPTH(PIXEL_LATENCY), .T(bar_rgb_t)) u_pat_dly (
    .clk  (clock_162),
    .rst  (rst),
    .din  (pat0),
    .dout (pat_dly)
  );

  assign src_r     = {COLOR_W{pat_dly.r}};
  assign src_g     = {COLOR_W{pat_dly.g}};
  assign src_b     = {COLOR_W{pat_dly.b}};
  assign unused_px = ^{px_r, px_g, px_b};
`else
  assign src_r = px_r;
  assign src_g = px_g;
  assign src_b = px_b;
`endif

  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  always_comb begin
    hsync_d = ctl_dly.hs ~^ HS_POL;
    vsync_d = ctl_dly.vs ~^ VS_POL;
    red_d   = ctl_dly.de ? src_r : '0;
    green_d = ctl_dly.de ? src_g : '0;
    blue_d  = ctl_dly.de ? src_b : '0;
  end

  always_ff @(posedge clock_162) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign RED   = red_q;
  assign GREEN = green_q;
  assign BLUE  = blue_q;

endmodule
